alu_cmd_sequencer: RTL

Operator-input front end for the 8-bit ALU accumulator stage. It debounces a raw push-button, and on each clean press it captures the current opcode and data switch values into a small command FIFO. When the operator enables it, it presents the queued commands one at a time to the accumulator, using a valid/ready handshake. The accumulator treats `out_valid & out_ready` as its step enable, so each queued command produces exactly one accumulator update.

---
 rtl/alu_cmd_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Operator front end for the 8-bit ALU accumulator stage. A raw push-button
// is synchronized and debounced. Each clean press captures {sw_opcode, sw_data}
// into a small circular command FIFO. While run=1 the FIFO head is offered to
// the accumulator one command per handshake.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   key_in                raw push-button, active-high, asynchronous to clk
//   sw_opcode, sw_data    switch values, sampled on the capture edge
//   run                   level; 1 lets the FIFO drain to the output
//   out_ready             downstream accepts the head command this cycle
//   out_valid             head command presented
//   out_opcode, out_data  head command (show-ahead)
//   count, full, empty    FIFO occupancy status, derived from registers
//   overflow              sticky: a press was dropped because the FIFO was full
//   dbg_state             debounce FSM state, for observation only
//
// Handshake: a transfer happens on every rising clk edge where
// out_valid & out_ready are both 1. out_valid depends only on registers and
// run, never on out_ready. out_valid may fall without a transfer when run
// drops; out_opcode/out_data are stable while out_valid=1 and no transfer
// has happened yet.
module alu_cmd_sequencer #(
  parameter int DEPTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     key_in,
  input  logic [2:0]               sw_opcode,
  input  logic [7:0]               sw_data,
  input  logic                     run,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [2:0]               out_opcode,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [1:0]               dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [DW-1:0] CNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_PEND   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_PEND = 2'd3
  } db_state_t;

  // Two-flop synchronizer for the asynchronous key.
  logic k_meta, ks;

  always_ff @(posedge clk) begin
    if (reset) begin
      k_meta <= 1'b0;
      ks     <= 1'b0;
    end else begin
      k_meta <= key_in;
      ks     <= k_meta;
    end
  end

  // Debounce FSM. Reset lands in S_PRESSED so a key held through reset has
  // to be seen released (debounced) before it can capture again.
  db_state_t     state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          push;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_PRESSED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    case (state_q)
      S_RELEASED: begin
        if (ks) begin
          state_d = S_PRESS_PEND;
          cnt_d   = DW'(1);
        end
      end
      S_PRESS_PEND: begin
        if (!ks) begin
          state_d = S_RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_PRESSED;
          push    = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      S_PRESSED: begin
        if (!ks) begin
          state_d = S_RELEASE_PEND;
          cnt_d   = DW'(1);
        end
      end
      S_RELEASE_PEND: begin
        if (ks) begin
          state_d = S_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RELEASED;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: begin
        state_d = S_PRESSED;
        cnt_d   = '0;
      end
    endcase
  end

  assign dbg_state = state_q;

  // Command FIFO: circular buffer with wrapping pointers and an occupancy count.
  logic [10:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [10:0]   head, last_q;
  logic          pop, push_ok;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign out_valid = run & ~empty;
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push & (~full | pop);
  assign head      = mem[rd_ptr];

  // When empty, keep showing the last command that left, not a stale slot.
  assign out_opcode = empty ? last_q[10:8] : head[10:8];
  assign out_data   = empty ? last_q[7:0]  : head[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      last_q   <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        last_q <= head;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= {sw_opcode, sw_data};
    end
  end

endmodule
